// File: rtl/ex_issue_stage.sv
// EX issue stage: registers a decoded instruction, decodes the ALU opcode,
// and forwards EX/MEM and MEM/WB results onto the held operands.
module ex_issue_stage #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         flush,
  input  logic [1:0]   alu_op,
  input  logic [2:0]   funct3,
  input  logic         funct7_5,
  input  logic [4:0]   rs1_addr,
  input  logic [4:0]   rs2_addr,
  input  logic [4:0]   rd_addr_in,
  input  logic [n-1:0] rs1_data,
  input  logic [n-1:0] rs2_data,
  input  logic [n-1:0] imm,
  input  logic         alu_src,
  input  logic         reg_write_in,
  input  logic         exmem_reg_write,
  input  logic [4:0]   exmem_rd,
  input  logic [n-1:0] exmem_result,
  input  logic         memwb_reg_write,
  input  logic [4:0]   memwb_rd,
  input  logic [n-1:0] memwb_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] alu_a,
  output logic [n-1:0] alu_b,
  output logic [3:0]   alu_select,
  output logic         alu_cin,
  output logic [n-1:0] store_data,
  output logic [4:0]   rd_out,
  output logic         reg_write_out,
  output logic         illegal,
  output logic [15:0]  stall_cnt
);

  typedef struct packed {
    logic [3:0]   sel;
    logic         ill;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic [n-1:0] rs1_data;
    logic [n-1:0] rs2_data;
    logic [n-1:0] imm;
    logic         alu_src;
    logic         reg_write;
  } hold_t;

  hold_t        hold_q, hold_d;
  logic         valid_q, valid_d;
  logic [15:0]  stall_q, stall_d;
  logic         capture;
  logic [3:0]   dec_sel;
  logic         dec_ill;
  logic [n-1:0] fwd_a, fwd_b;

  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  always_comb begin
    dec_sel = 4'b1111;
    dec_ill = 1'b1;
    unique case (1'b1)
      alu_op == 2'b00: begin
        dec_sel = 4'b0010;
        dec_ill = 1'b0;
      end
      alu_op == 2'b01: begin
        dec_sel = 4'b0110;
        dec_ill = 1'b0;
      end
      alu_op == 2'b10 && funct3 == 3'b000: begin
        dec_sel = funct7_5 ? 4'b0110 : 4'b0010;
        dec_ill = 1'b0;
      end
      alu_op == 2'b10 && funct3 == 3'b111: begin
        dec_sel = 4'b0000;
        dec_ill = 1'b0;
      end
      alu_op == 2'b10 && funct3 == 3'b110: begin
        dec_sel = 4'b0001;
        dec_ill = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    hold_d  = hold_q;
    stall_d = stall_q;
    // flush beats capture; an accepted-but-flushed input is simply lost
    if (flush)
      valid_d = 1'b0;
    else if (capture)
      valid_d = 1'b1;
    else if (valid_q && out_ready)
      valid_d = 1'b0;
    if (capture) begin
      hold_d.sel       = dec_sel;
      hold_d.ill       = dec_ill;
      hold_d.rs1       = rs1_addr;
      hold_d.rs2       = rs2_addr;
      hold_d.rd        = rd_addr_in;
      hold_d.rs1_data  = rs1_data;
      hold_d.rs2_data  = rs2_data;
      hold_d.imm       = imm;
      hold_d.alu_src   = alu_src;
      hold_d.reg_write = reg_write_in;
    end
    if (valid_q && !out_ready && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      hold_q  <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      hold_q  <= hold_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    fwd_a = hold_q.rs1_data;
    fwd_b = hold_q.rs2_data;
    if (exmem_reg_write && exmem_rd == hold_q.rs1 && hold_q.rs1 != 5'd0)
      fwd_a = exmem_result;
    else if (memwb_reg_write && memwb_rd == hold_q.rs1 && hold_q.rs1 != 5'd0)
      fwd_a = memwb_result;
    if (exmem_reg_write && exmem_rd == hold_q.rs2 && hold_q.rs2 != 5'd0)
      fwd_b = exmem_result;
    else if (memwb_reg_write && memwb_rd == hold_q.rs2 && hold_q.rs2 != 5'd0)
      fwd_b = memwb_result;
  end

  assign out_valid     = valid_q;
  assign alu_a         = fwd_a;
  assign alu_b         = hold_q.alu_src ? hold_q.imm : fwd_b;
  assign store_data    = fwd_b;
  assign alu_select    = hold_q.sel;
  assign alu_cin       = 1'b0;
  assign rd_out        = hold_q.rd;
  assign reg_write_out = hold_q.reg_write && valid_q;
  assign illegal       = hold_q.ill;
  assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Scoreboard bench for ex_issue_stage: directed vectors push expected
// results, a negedge monitor pops them on every output handshake.
module tb_ex_issue_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr_in;
  logic [31:0] rs1_data, rs2_data, imm;
  logic        alu_src, reg_write_in;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        out_valid, out_ready;
  logic [31:0] alu_a, alu_b, store_data;
  logic [3:0]  alu_select;
  logic        alu_cin, reg_write_out, illegal;
  logic [4:0]  rd_out;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a, b, sd;
    logic [3:0]  sel;
    logic        ill;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;
  exp_t sb[$];

  ex_issue_stage #(.n(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr_in(rd_addr_in),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .alu_src(alu_src), .reg_write_in(reg_write_in),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
    .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
    .alu_cin(alu_cin), .store_data(store_data), .rd_out(rd_out),
    .reg_write_out(reg_write_out), .illegal(illegal),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=rd%0d required=none", rd_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_alu_a", alu_a, e.a);
        chk("sb_alu_b", alu_b, e.b);
        chk("sb_store_data", store_data, e.sd);
        chk("sb_alu_select", {28'd0, alu_select}, {28'd0, e.sel});
        chk("sb_illegal", {31'd0, illegal}, {31'd0, e.ill});
        chk("sb_rd_out", {27'd0, rd_out}, {27'd0, e.rd});
        chk("sb_reg_write", {31'd0, reg_write_out}, {31'd0, e.rw});
        chk("sb_alu_cin", {31'd0, alu_cin}, 32'd0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic [1:0] op, input logic [2:0] f3, input logic f75,
    input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
    input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im,
    input logic src, input logic rw, input logic push,
    input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] esd,
    input logic [3:0] esel, input logic eill);
    exp_t e;
    in_valid = 1'b1;
    alu_op = op; funct3 = f3; funct7_5 = f75;
    rs1_addr = r1; rs2_addr = r2; rd_addr_in = rd;
    rs1_data = d1; rs2_data = d2; imm = im;
    alu_src = src; reg_write_in = rw;
    if (push) begin
      e.a = ea; e.b = eb; e.sd = esd; e.sel = esel;
      e.ill = eill; e.rd = rd; e.rw = rw;
      sb.push_back(e);
    end
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] er,
                         input logic [31:0] ed, input logic mw,
                         input logic [4:0] mr, input logic [31:0] md);
    exmem_reg_write = ew; exmem_rd = er; exmem_result = ed;
    memwb_reg_write = mw; memwb_rd = mr; memwb_result = md;
  endtask

  task automatic reset_dut;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    alu_op = '0; funct3 = '0; funct7_5 = 1'b0;
    rs1_addr = '0; rs2_addr = '0; rd_addr_in = '0;
    rs1_data = '0; rs2_data = '0; imm = '0;
    alu_src = 1'b0; reg_write_in = 1'b0;
    set_fwd(0, 0, 0, 0, 0, 0);

    // reset state
    repeat (3) tick;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_alu_select", {28'd0, alu_select}, 32'd0);
    chk("rst_rd_out", {27'd0, rd_out}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    tick;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // back-to-back decode vectors
    tick;
    drive(2'b10, 3'b000, 1, 1, 2, 3, 9, 4, 0, 0, 1, 1,
          9, 4, 4, 4'b0110, 0);
    tick;
    drive(2'b00, 3'b010, 0, 4, 5, 6, 100, 7, 12, 1, 0, 1,
          100, 12, 7, 4'b0010, 0);
    tick;
    drive(2'b01, 3'b000, 0, 7, 8, 0, 50, 20, 0, 0, 0, 1,
          50, 20, 20, 4'b0110, 0);
    tick;
    drive(2'b10, 3'b111, 0, 1, 2, 9, 32'hF0, 32'h3C, 0, 0, 1, 1,
          32'hF0, 32'h3C, 32'h3C, 4'b0000, 0);
    tick;
    drive(2'b10, 3'b110, 0, 1, 2, 10, 32'hF0, 32'h3C, 0, 0, 1, 1,
          32'hF0, 32'h3C, 32'h3C, 4'b0001, 0);
    tick;
    drive(2'b10, 3'b000, 0, 1, 2, 11, 3, 5, 32'hFFFF_FFFF, 1, 1, 1,
          3, 32'hFFFF_FFFF, 5, 4'b0010, 0);
    tick;
    drive(2'b10, 3'b001, 0, 1, 2, 12, 1, 2, 0, 0, 1, 1,
          1, 2, 2, 4'b1111, 1);
    tick;
    drive(2'b11, 3'b000, 0, 1, 2, 13, 1, 2, 0, 0, 0, 1,
          1, 2, 2, 4'b1111, 1);
    tick;
    in_valid = 1'b0;
    tick;
    tick;

    // forwarding priority on a held instruction
    out_ready = 1'b0;
    drive(2'b00, 3'b000, 0, 5, 6, 7, 32'h11, 32'h22, 0, 0, 1, 1,
          32'h11, 32'h22, 32'h22, 4'b0010, 0);
    tick;
    in_valid = 1'b0;
    set_fwd(1, 5, 32'hAA, 1, 5, 32'hBB);
    @(negedge clk);
    chk("fwd_exmem_wins", alu_a, 32'hAA);
    #1 exmem_reg_write = 1'b0;
    #1 chk("fwd_memwb_a", alu_a, 32'hBB);
    memwb_rd = 5'd6;
    #1 chk("fwd_memwb_b", alu_b, 32'hBB);
    chk("fwd_store_data", store_data, 32'hBB);
    chk("fwd_a_held", alu_a, 32'h11);
    set_fwd(0, 0, 0, 0, 0, 0);
    tick;
    out_ready = 1'b1;
    tick;
    // x0 is never forwarded
    set_fwd(1, 0, 32'hAA, 1, 0, 32'hBB);
    drive(2'b00, 3'b000, 0, 0, 0, 8, 32'h77, 32'h66, 0, 0, 1, 1,
          32'h77, 32'h66, 32'h66, 4'b0010, 0);
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    set_fwd(0, 0, 0, 0, 0, 0);

    // back-pressure for 3 cycles, then drain with same-cycle capture
    reset_dut;
    drive(2'b10, 3'b000, 0, 1, 2, 14, 32'h30, 32'h0C, 0, 0, 1, 1,
          32'h30, 32'h0C, 32'h0C, 4'b0010, 0);
    tick;
    out_ready = 1'b0;
    drive(2'b10, 3'b000, 1, 1, 2, 15, 32'h40, 32'h01, 0, 0, 1, 1,
          32'h40, 32'h01, 32'h01, 4'b0110, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_alu_a", alu_a, 32'h30);
      chk("stall_rd_out", {27'd0, rd_out}, 32'd14);
      tick;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_cnt_3", {16'd0, stall_cnt}, 32'd3);
    tick;
    in_valid = 1'b0;
    @(negedge clk);
    chk("refill_valid", {31'd0, out_valid}, 32'd1);
    chk("refill_rd", {27'd0, rd_out}, 32'd15);
    tick;

    // flush while empty drops the input
    drive(2'b00, 3'b000, 0, 1, 2, 16, 1, 2, 0, 0, 1, 0,
          0, 0, 0, 0, 0);
    flush = 1'b1;
    #1 chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_empty_valid", {31'd0, out_valid}, 32'd0);
    // flush while holding
    tick;
    out_ready = 1'b0;
    drive(2'b00, 3'b000, 0, 1, 2, 17, 1, 2, 0, 0, 1, 0,
          0, 0, 0, 0, 0);
    tick;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_held_valid", {31'd0, out_valid}, 32'd1);
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_held_cleared", {31'd0, out_valid}, 32'd0);
    chk("flush_reg_write", {31'd0, reg_write_out}, 32'd0);

    // stall counter saturation, then reset mid-stall
    reset_dut;
    drive(2'b00, 3'b000, 0, 1, 2, 18, 1, 2, 0, 0, 1, 0,
          0, 0, 0, 0, 0);
    tick;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (65534) tick;
    @(negedge clk);
    chk("stall_cnt_fffe", {16'd0, stall_cnt}, 32'h0000_FFFE);
    repeat (3) tick;
    @(negedge clk);
    chk("stall_cnt_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
    tick;
    rst = 1'b1;
    tick;
    @(negedge clk);
    chk("rst_stall_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick;
    tick;

    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_issue_stage.md
EX_ISSUE_STAGE -- requirements
Module: ex_issue_stage

Interface
REQ-001 Parameter: n, 32, datapath width; it SHALL match the downstream ALU width.
REQ-002 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 in_valid  in  1  decode stage presents an instruction.
REQ-005 in_ready  out  1  stage can accept; SHALL equal !out_valid || out_ready (combinational).
REQ-006 flush  in  1  kill the held instruction (branch redirect).
REQ-007 alu_op  in  2  00 mem-address, 01 branch-compare, 10 arith/logic, 11 reserved.
REQ-008 funct3  in  3 / funct7_5  in  1  instruction function fields.
REQ-009 rs1_addr, rs2_addr, rd_addr_in  in  5 each  register indices.
REQ-010 rs1_data, rs2_data, imm  in  n each  register-file operands and sign-extended immediate.
REQ-011 alu_src  in  1  1 selects imm as operand B; reg_write_in  in  1  writeback enable.
REQ-012 exmem_reg_write  in  1, exmem_rd  in  5, exmem_result  in  n  EX/MEM forwarding source.
REQ-013 memwb_reg_write  in  1, memwb_rd  in  5, memwb_result  in  n  MEM/WB forwarding source.
REQ-014 out_valid  out  1 / out_ready  in  1  handshake toward the ALU/EX-MEM boundary.
REQ-015 alu_a, alu_b  out  n  ALU operands; alu_select  out  4  ALU opcode; alu_cin  out  1, constant 0.
REQ-016 store_data  out  n  forwarded rs2 value; rd_out  out  5; reg_write_out  out  1.
REQ-017 illegal  out  1  held instruction has an undecodable ALU operation.
REQ-018 stall_cnt  out  16  count of back-pressure cycles.

Function
REQ-019 Capture SHALL occur when in_valid && in_ready && !flush; all fields are registered, and out_valid is 1 on the next cycle (latency 1).
REQ-020 When out_valid && out_ready && !capture, out_valid SHALL clear on the next cycle; back-to-back capture/drain SHALL sustain 1 instruction per cycle.
REQ-021 While out_valid && !out_ready, all held fields SHALL remain stable.
REQ-022 Flush SHALL clear out_valid on the next cycle and SHALL take priority over a simultaneous capture; the flushed input is dropped and in_ready is unaffected.
REQ-023 Decode (registered at capture): alu_op 00 -> 0010 (add); 01 -> 0110 (sub); 10 with funct3 000 -> 0110 if funct7_5 else 0010; 10/111 -> 0000 (AND); 10/110 -> 0001 (OR).
REQ-024 Any other alu_op/funct3 combination SHALL register alu_select 1111 and illegal=1; otherwise illegal=0.
REQ-025 Forwarding SHALL be combinational on the held rs addresses against the current EX/MEM and MEM/WB inputs.
REQ-026 Operand A = exmem_result if exmem_reg_write && exmem_rd==rs1 && rs1!=0; else memwb_result under the same rule for MEM/WB; else the held rs1_data.
REQ-027 Forwarded rs2 SHALL use the same rule and priority, with EX/MEM winning over MEM/WB.
REQ-028 Register x0 SHALL never be forwarded.
REQ-029 alu_b SHALL equal held imm when held alu_src=1, else forwarded rs2; store_data SHALL always equal forwarded rs2.
REQ-030 reg_write_out SHALL equal held reg_write_in && out_valid (0 when no valid instruction).
REQ-031 stall_cnt SHALL increment each cycle out_valid && !out_ready, saturating at 16'hFFFF without wrap.

Reset
REQ-032 With rst=1 at a clock edge: out_valid=0, illegal=0, stall_cnt=0, alu_select=0000, rd_out=0, and all held data=0.
REQ-033 Reset SHALL override a simultaneous capture, flush or drain.
REQ-034 A held instruction SHALL be discarded when rst asserts mid-stall.
REQ-035 in_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-036 Capture alu_op=10, funct3=000, funct7_5=1, rs1_data=9, rs2_data=4, alu_src=0 with out_ready=1 -> next cycle out_valid=1, alu_select=0110, alu_a=9, alu_b=4.
REQ-037 Held rs1=5 with exmem (we=1, rd=5, 0xAA) and memwb (we=1, rd=5, 0xBB) both matching -> alu_a=0xAA; drop exmem_reg_write -> alu_a=0xBB; rs1=0 with rd=0 matches -> alu_a=held rs1_data.
REQ-038 Hold out_ready=0 for 3 cycles after a capture -> outputs stable, in_ready=0, stall_cnt=3; then out_ready=1 -> drains, and a new capture occurs in the same cycle.
REQ-039 flush=1 coincident with in_valid=1 while empty -> out_valid stays 0; flush while holding -> out_valid=0 next cycle.
REQ-040 alu_op=10, funct3=001 -> alu_select=1111, illegal=1; alu_op=11 -> same.
REQ-041 Force stall_cnt to 0xFFFE, then stall 3 cycles -> stall_cnt=0xFFFF with no wrap; assert rst mid-stall -> out_valid=0, stall_cnt=0 next cycle.
